// File: rtl/pixel_upsampler.sv
// Reader-side pixel upsampler: expands packed RRRBBBGG pixels from frame
// memory to RGB565 by bit replication and tags each pixel with its raster
// position. A two-entry output stage (output register + skid register)
// keeps in_ready registered so it never depends combinationally on out_ready.
module pixel_upsampler #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_restart,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_pixel,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [15:0]   out_pixel,
  output logic          out_sol,
  output logic          out_eol,
  output logic          out_sof,
  output logic          out_eof,
  output logic [XW-1:0] x_pos,
  output logic [YW-1:0] y_pos
);

  // Replicate the high bits of each narrow channel into the vacated low bits
  // so that all-zeros and all-ones channels map to full black and full white.
  function automatic logic [15:0] expand(input logic [7:0] p);
    logic [2:0] r;
    logic [2:0] b;
    logic [1:0] g;
    r = p[7:5];
    b = p[4:2];
    g = p[1:0];
    return {r, r[2:1], g, g, g, b, b[2:1]};
  endfunction

  logic        skid_valid;
  logic        skid_next;
  logic [15:0] skid_pixel;
  logic [15:0] new_pixel;
  logic        in_fire;
  logic        out_fire;
  logic        load_out;
  logic        last_x;
  logic        last_y;

  assign new_pixel = expand(in_pixel);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // The output register may take new data when empty or being drained.
  assign load_out  = out_fire | ~out_valid;
  assign last_x    = (x_pos == XW'(WIDTH - 1));
  assign last_y    = (y_pos == YW'(HEIGHT - 1));

  // Next occupancy of the skid register, used to register in_ready.
  always_comb begin
    skid_next = skid_valid;
    if (load_out) begin
      if (skid_valid && !in_fire) begin
        skid_next = 1'b0;
      end
    end else if (in_fire) begin
      skid_next = 1'b1;
    end
  end

  // Output/skid data path: skid always drains first so ordering stays FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_pixel  <= 16'h0000;
      skid_valid <= 1'b0;
      skid_pixel <= 16'h0000;
      in_ready   <= 1'b0;
    end else begin
      if (load_out) begin
        if (skid_valid) begin
          out_pixel <= skid_pixel;
          out_valid <= 1'b1;
          if (in_fire) begin
            skid_pixel <= new_pixel;
          end
        end else if (in_fire) begin
          out_pixel <= new_pixel;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_fire) begin
        skid_pixel <= new_pixel;
      end
      skid_valid <= skid_next;
      in_ready   <= ~skid_next;
    end
  end

  // Raster position of the presented pixel; restart wins over advancing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (frame_restart) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (out_fire) begin
      if (last_x) begin
        x_pos <= '0;
        if (last_y) begin
          y_pos <= '0;
        end else begin
          y_pos <= y_pos + YW'(1);
        end
      end else begin
        x_pos <= x_pos + XW'(1);
      end
    end
  end

  assign out_sol = out_valid & (x_pos == '0);
  assign out_eol = out_valid & last_x;
  assign out_sof = out_valid & (x_pos == '0) & (y_pos == '0);
  assign out_eof = out_valid & last_x & last_y;

endmodule

// File: doc/pixel_upsampler.md
Name: pixel_upsampler

Overview:
- Reader-side counterpart of the camera downsampler.
- Consumes packed 8-bit RRRBBBGG pixels from frame memory and expands each to 16-bit RGB565 by bit replication.
- Tags each pixel with raster position markers for the display/VGA path.
- Sits between the frame-buffer read port and the display driver:
  - valid/ready on both sides;
  - 2-entry skid buffer so the pipeline never drops a pixel under backpressure.

Parameters:
- WIDTH, 640, active pixels per line (at least 2).
- HEIGHT, 480, active lines per frame (at least 2).
- XW, 10, width of the x counter (2^XW must be at least WIDTH).
- YW, 9, width of the y counter (2^YW must be at least HEIGHT).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- frame_restart  input  1  synchronous pulse; resets the raster position to (0,0).
- in_valid  input  1  in_pixel is valid.
- in_ready  output  1  block can accept in_pixel this cycle.
- in_pixel  input  8  packed pixel: [7:5]=red, [4:2]=blue, [1:0]=green.
- out_valid  output  1  out_pixel and the markers are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_pixel  output  16  RGB565: [15:11]=R5, [10:5]=G6, [4:0]=B5.
- out_sol  output  1  pixel is the first of its line (x==0).
- out_eol  output  1  pixel is the last of its line (x==WIDTH-1).
- out_sof  output  1  pixel is the first of the frame (x==0, y==0).
- out_eof  output  1  pixel is the last of the frame (x==WIDTH-1, y==HEIGHT-1).
- x_pos  output  XW  x coordinate of the current out pixel.
- y_pos  output  YW  y coordinate of the current out pixel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, in_ready=0;
  - out_pixel=0, all markers=0;
  - x_pos=0, y_pos=0;
  - skid buffer empty.
- First cycle after rst_n rises: in_ready=1.
- Expansion (combinational on accept, stored registered), with r=in[7:5], b=in[4:2], g=in[1:0]:
  - R5={r,r[2:1]};
  - G6={g,g,g};
  - B5={b,b[2:1]};
  - 0x00 maps to 0x0000; 0xFF maps to 0xFFFF.
- Handshakes:
  - Input handshake: in_valid and in_ready in the same cycle.
  - Output handshake: out_valid and out_ready in the same cycle.
  - Latency: one cycle from input handshake to out_valid when the output stage is empty.
  - Throughput: 1 pixel/clk while out_ready is held high.
- Skid buffer / output stage occupancy:
  - Storage is the output register plus one skid register.
  - in_ready is registered and equals "skid register empty". It never depends combinationally on out_ready.
  - Output stage valid and out_ready low with an input accepted: the new pixel goes into the skid register and in_ready drops on the next cycle.
  - Output handshake with skid full: skid contents move to the output register and in_ready rises on the next cycle.
  - Output handshake and input handshake in the same cycle: ordering is preserved (FIFO). No pixel is lost or duplicated.
  - out_valid held with out_ready low: out_pixel, markers and x_pos/y_pos stay stable.
- Raster position:
  - Tracks the pixel currently presented on out_pixel.
  - Advances on each output handshake: x increments; at x==WIDTH-1 it wraps to 0 and y increments; at y==HEIGHT-1 with x==WIDTH-1, y wraps to 0.
  - Markers are combinational decodes of (x_pos, y_pos), qualified by out_valid, so they are 0 whenever out_valid=0.
- frame_restart:
  - Sets x_pos=0, y_pos=0 on the next edge.
  - Pixel data in the buffers is not flushed.
  - Takes priority over a same-cycle output-handshake advance.
- Reset mid-stream: all buffered pixels are discarded and the position returns to (0,0).

Test Plan:
- Reset, then send 0x00, 0xFF, 0xE0, 0x1C, 0x03 back-to-back with out_ready=1 -> out_pixel 0x0000, 0xFFFF, 0xF800, 0x001F, 0x07E0, one cycle after each accept, one per clk.
- Send 0xA5 (r=5, b=1, g=1) -> out_pixel R5=10110 (0x16), G6=010101, B5=00100 -> 0xB2A4.
- Stream 4 pixels with out_ready low from cycle 2 -> in_ready drops after 2 accepts. Raise out_ready -> all 4 pixels emerge in order, out_pixel stable while stalled.
- With WIDTH=4, HEIGHT=3, stream 12 pixels -> out_sof on pixel 0; out_sol on pixels 0, 4, 8; out_eol on pixels 3, 7, 11; out_eof on pixel 11. Pixel 12 reports (0,0) with out_sof=1.
- Pulse frame_restart at x=2, y=1 -> next pixel reports x_pos=0, y_pos=0, out_sof=1, with no data lost.
- Assert rst_n low mid-stream with the skid buffer full -> out_valid=0 and in_ready=0 immediately. After release, the first new pixel appears alone with out_sof=1.
